lenet_result_collector: RTL and testbench
=========================================

# lenet_result_collector

Consumer at the output end of the `lenet` classifier. Accepts the stream of per-class scores on `finalresult`, tracks the signed maximum, and reports the winning class index and score once per frame with a single-cycle `done` pulse. Sits directly after the final fully connected layer. It replaces stimulus-side observation with an on-chip classification result.

## Interface
Parameters:
- `DATA_WIDTH`, 16: score width, two's complement.
- `NUM_CLASSES`, 10: scores per frame, 2..2^`CLASS_ADDR_WIDTH`.
- `CLASS_ADDR_WIDTH`, 4: width of the class index and the sample counter.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: global run enable. While low, all state and outputs hold and inputs are ignored.
- `result_valid`  in  1: `finalresult` carries a score this cycle.
- `finalresult`  in  `DATA_WIDTH`: signed class score, classes arrive in index order 0..`NUM_CLASSES`-1.
- `result_last`  in  1: marks the final score of a frame; qualified by `result_valid`.
- `class_index`  out  `CLASS_ADDR_WIDTH`: argmax of the last completed frame.
- `max_score`  out  `DATA_WIDTH`: score at `class_index`.
- `done`  out  1: one-cycle pulse when `class_index`/`max_score` update.
- `busy`  out  1: high while a frame is partially received.
- `frame_error`  out  1: sticky frame-length error; cleared only by `reset`.

## Operation
- A sample is accepted when `enable && result_valid`.
- FSM states:
  - IDLE: waiting for the first sample of a frame. On accept, load running max = sample, running index = 0, count = 1, go to ACCUM. If that sample is also terminal, go straight to REPORT.
  - ACCUM: on each accept, if sample > running max (signed, strict), load max = sample and index = count. Then count += 1. A sample is terminal when count == `NUM_CLASSES`-1 before the increment. Go to REPORT after the terminal sample.
  - REPORT: one cycle. Copy the running max and index to the outputs, pulse `done`, return to IDLE. Samples presented in REPORT are not accepted; upstream must not assert `result_valid` in that cycle.
- Ties: the lowest index wins, so an equal later score never replaces the current max.
- Comparison is full-width signed, with no saturation or truncation.
- `busy` = (state == ACCUM).
- Counter width is `CLASS_ADDR_WIDTH`. It never wraps because the frame terminates at `NUM_CLASSES`.
- Reset mid-frame: the partial frame is discarded and the outputs return to their reset values. The next accepted sample starts a new frame.
- `enable` low mid-frame: the frame resumes exactly where it stopped. `done` cannot pulse while `enable` is low; REPORT holds until `enable` returns.

## Timing
- Reset values:
  - `class_index` = 0, `max_score` = 0, `done` = 0, `busy` = 0, `frame_error` = 0.
  - State = IDLE, counters cleared.
- Latency: the terminal sample is accepted at edge N. `done`, `class_index` and `max_score` are valid in the cycle after edge N+1.
- Outputs are registered and stay stable between `done` pulses.
- Minimum frame period is `NUM_CLASSES`+1 cycles, because of the REPORT bubble.
- `reset` dominates `enable` and `result_valid` in the same cycle.

## Configuration
- `LENET_COLLECT_FRAME_CHECK_EN` defined:
  - `result_last` is checked against the count.
  - `result_last` on a non-terminal sample: set `frame_error` and terminate the frame early, reporting the argmax of the samples received so far.
  - Terminal sample without `result_last`: set `frame_error`, but still report normally.
- Not defined: `result_last` is ignored, the frame ends on count alone, and `frame_error` is tied to 0.

## Test plan
- Basic argmax: after reset, stream scores 3,-1,7,2,0,5,7,1,-4,6 on consecutive cycles, with `result_last` on the 10th. Expect `done` one cycle after REPORT entry, `class_index` = 2, `max_score` = 7 (tie at index 6 loses), and `frame_error` = 0.
- All negative: scores -100..-91 with -91 at index 9. Expect `class_index` = 9, `max_score` = 16'hFFA5 (-91).
- Enable stall: frame as in the basic case with `enable` dropped for 5 cycles after the 4th sample. Expect an identical result, `busy` held high during the stall, and `done` delayed by 5 cycles.
- Reset mid-frame: 6 samples, pulse `reset`, then a full frame of 0,0,0,0,0,0,0,0,0,1. Expect `class_index` = 9, `max_score` = 1, and exactly one `done`.
- Back-to-back frames: two frames separated by exactly one idle cycle. Expect two `done` pulses with each result correct, and outputs held between the pulses.
- Length error (macro defined): `result_last` on the 4th sample of 9,8,20,1. Expect `frame_error` = 1, `class_index` = 2, `max_score` = 20, and `frame_error` still 1 after the next good frame.

Source files
------------

// File: rtl/lenet_result_collector.sv
// Argmax collector for the lenet score stream; reports class and score per frame.
// Optional LENET_COLLECT_FRAME_CHECK_EN checks result_last against the count.
module lenet_result_collector #(
  parameter int DATA_WIDTH       = 16,
  parameter int NUM_CLASSES      = 10,
  parameter int CLASS_ADDR_WIDTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        result_valid,
  input  logic [DATA_WIDTH-1:0]       finalresult,
  input  logic                        result_last,
  output logic [CLASS_ADDR_WIDTH-1:0] class_index,
  output logic [DATA_WIDTH-1:0]       max_score,
  output logic                        done,
  output logic                        busy,
  output logic                        frame_error
);

  localparam int CAW = CLASS_ADDR_WIDTH;
  localparam logic [CAW-1:0] LAST_IDX = CAW'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_REPORT
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [CAW-1:0]        idx_q, idx_d;
  logic [CAW-1:0]        cnt_q, cnt_d;
  logic [CAW-1:0]        cls_q, cls_d;
  logic [DATA_WIDTH-1:0] score_q, score_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic accept;
  logic terminal;
  logic early;
  logic miss;
  logic bigger;

  assign accept   = enable && result_valid;
  // cnt_q is zero in IDLE, so one compare serves both states
  assign terminal = (cnt_q == LAST_IDX);
  assign bigger   = $signed(finalresult) > $signed(max_q);

`ifdef LENET_COLLECT_FRAME_CHECK_EN
  assign early = result_last && !terminal;
  assign miss  = !result_last && terminal;
`else
  logic unused_last;
  assign unused_last = result_last;
  assign early = 1'b0;
  assign miss  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cls_d   = cls_q;
    score_d = score_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          max_d   = finalresult;
          idx_d   = '0;
          cnt_d   = CAW'(1);
          state_d = (terminal || early) ? S_REPORT : S_ACCUM;
          if (early || miss) err_d = 1'b1;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          if (bigger) begin
            max_d = finalresult;
            idx_d = cnt_q;
          end
          cnt_d = cnt_q + CAW'(1);
          if (terminal || early) state_d = S_REPORT;
          if (early || miss) err_d = 1'b1;
        end
      end
      S_REPORT: begin
        if (enable) begin
          cls_d   = idx_q;
          score_d = max_q;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      max_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      cls_q   <= '0;
      score_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      score_q <= score_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign class_index = cls_q;
  assign max_score   = score_q;
  assign done        = done_q;
  assign busy        = (state_q == S_ACCUM);
  assign frame_error = err_q;

endmodule

// File: tb/tb_lenet_result_collector.sv
// Bench for lenet_result_collector: queue-based argmax model plus directed cases.
module tb_lenet_result_collector;

  localparam int DW = 16;
  localparam int NC = 10;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          result_valid = 1'b0;
  logic [DW-1:0] finalresult = '0;
  logic          result_last = 1'b0;
  logic [CW-1:0] class_index;
  logic [DW-1:0] max_score;
  logic          done;
  logic          busy;
  logic          frame_error;

  lenet_result_collector #(
    .DATA_WIDTH(DW),
    .NUM_CLASSES(NC),
    .CLASS_ADDR_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .result_valid(result_valid),
    .finalresult(finalresult),
    .result_last(result_last),
    .class_index(class_index),
    .max_score(max_score),
    .done(done),
    .busy(busy),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // reference model: collect the frame, argmax it when reported
  logic signed [DW-1:0] fq[$];
  bit            pend = 0;
  logic [CW-1:0] e_idx = '0;
  logic [DW-1:0] e_score = '0;
  bit            e_done = 0;
  bit            e_err = 0;

  task automatic model_step();
    int bi;
    if (reset) begin
      fq.delete();
      pend = 0; e_idx = '0; e_score = '0; e_done = 0; e_err = 0;
    end else if (enable) begin
      e_done = 0;
      if (pend) begin
        bi = 0;
        for (int i = 1; i < fq.size(); i++)
          if (fq[i] > fq[bi]) bi = i;
        e_idx = CW'(bi);
        e_score = fq[bi];
        e_done = 1;
        fq.delete();
        pend = 0;
      end else if (result_valid) begin
        fq.push_back(finalresult);
`ifdef LENET_COLLECT_FRAME_CHECK_EN
        if (result_last != (fq.size() == NC)) e_err = 1;
        if (result_last || fq.size() == NC) pend = 1;
`else
        if (fq.size() == NC) pend = 1;
`endif
      end
    end else begin
      e_done = 0;
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  bit  chk_en = 0;
  int  n_done = 0;
  time done_t = 0;
  logic [CW-1:0] dn_idx[$];
  logic [DW-1:0] dn_sc[$];

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      chk("done", {31'b0, done}, {31'b0, e_done});
      chk("class_index", {28'b0, class_index}, {28'b0, e_idx});
      chk("max_score", {16'b0, max_score}, {16'b0, e_score});
      chk("busy", {31'b0, busy}, {31'b0, (fq.size() > 0) && !pend});
      chk("frame_error", {31'b0, frame_error}, {31'b0, e_err});
      if (done === 1'b1) begin
        n_done++;
        done_t = $time;
        dn_idx.push_back(class_index);
        dn_sc.push_back(max_score);
      end
    end
  end

  task automatic drv(input bit en, input bit v, input logic [DW-1:0] d,
                     input bit l);
    @(negedge clock);
    enable = en;
    result_valid = v;
    finalresult = d;
    result_last = l;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1, 0, '0, 0);
  endtask

  logic [DW-1:0] fr[NC];
  time t_first, t_last;

  task automatic send_frame(input int stall_at);
    for (int i = 0; i < NC; i++) begin
      if (i == stall_at) begin
        repeat (5) begin
          drv(0, 0, '0, 0);
          chk("stall_busy", {31'b0, busy}, 32'd1);
        end
      end
      drv(1, 1, fr[i], i == NC - 1);
      if (i == 0) t_first = $time;
      t_last = $time;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (pend && k < 100) begin
      drv(($urandom_range(0, 3) != 0), 0, DW'($urandom), 0);
      k++;
    end
    if (k >= 100) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  time lat_basic;
  int  nd0;
  int  k;

  initial begin
    repeat (2) @(negedge clock);
    chk_en = 1;
    chk("rst_class", {28'b0, class_index}, 32'd0);
    chk("rst_score", {16'b0, max_score}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    idle(2);

    // basic argmax with a tie at index 6
    fr = '{16'd3, -16'sd1, 16'd7, 16'd2, 16'd0, 16'd5, 16'd7, 16'd1,
           -16'sd4, 16'd6};
    dn_idx.delete(); dn_sc.delete();
    send_frame(-1);
    idle(4);
    chk("basic_n", dn_idx.size(), 32'd1);
    if (dn_idx.size() > 0) begin
      chk("basic_idx", {28'b0, dn_idx[0]}, 32'd2);
      chk("basic_score", {16'b0, dn_sc[0]}, 32'd7);
    end
    chk("basic_lat", 32'(done_t - t_last), 32'd20);
    lat_basic = done_t - t_first;

    // all negative
    for (int i = 0; i < NC; i++) fr[i] = DW'(-100 + i);
    dn_idx.delete(); dn_sc.delete();
    send_frame(-1);
    idle(4);
    if (dn_idx.size() > 0) begin
      chk("neg_idx", {28'b0, dn_idx[0]}, 32'd9);
      chk("neg_score", {16'b0, dn_sc[0]}, 32'h0000ffa5);
    end else chk("neg_n", 32'd0, 32'd1);

    // enable stall after the 4th sample
    fr = '{16'd3, -16'sd1, 16'd7, 16'd2, 16'd0, 16'd5, 16'd7, 16'd1,
           -16'sd4, 16'd6};
    dn_idx.delete(); dn_sc.delete();
    send_frame(4);
    idle(4);
    if (dn_idx.size() > 0) begin
      chk("stall_idx", {28'b0, dn_idx[0]}, 32'd2);
      chk("stall_score", {16'b0, dn_sc[0]}, 32'd7);
    end else chk("stall_n", 32'd0, 32'd1);
    chk("stall_delay", 32'(done_t - t_first), 32'(lat_basic + 50));

    // reset mid-frame, then a fresh frame
    for (int i = 0; i < 6; i++) drv(1, 1, DW'(50 + i), 0);
    @(negedge clock);
    reset = 1'b1;
    result_valid = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    result_valid = 1'b0;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_class", {28'b0, class_index}, 32'd0);
    for (int i = 0; i < NC; i++) fr[i] = (i == NC - 1) ? 16'd1 : 16'd0;
    nd0 = n_done;
    dn_idx.delete(); dn_sc.delete();
    send_frame(-1);
    idle(4);
    chk("rst_frame_n", 32'(n_done - nd0), 32'd1);
    if (dn_idx.size() > 0) begin
      chk("rst_frame_idx", {28'b0, dn_idx[0]}, 32'd9);
      chk("rst_frame_score", {16'b0, dn_sc[0]}, 32'd1);
    end

    // back-to-back frames with only the REPORT bubble between them
    dn_idx.delete(); dn_sc.delete();
    fr = '{16'd3, -16'sd1, 16'd7, 16'd2, 16'd0, 16'd5, 16'd7, 16'd1,
           -16'sd4, 16'd6};
    send_frame(-1);
    idle(1);
    fr = '{-16'sd5, 16'd10, 16'd10, 16'd3, -16'sd20, 16'd0, 16'd4, 16'd9,
           16'd10, -16'sd1};
    send_frame(-1);
    idle(4);
    chk("b2b_n", dn_idx.size(), 32'd2);
    if (dn_idx.size() == 2) begin
      chk("b2b_idx0", {28'b0, dn_idx[0]}, 32'd2);
      chk("b2b_score0", {16'b0, dn_sc[0]}, 32'd7);
      chk("b2b_idx1", {28'b0, dn_idx[1]}, 32'd1);
      chk("b2b_score1", {16'b0, dn_sc[1]}, 32'd10);
    end

`ifdef LENET_COLLECT_FRAME_CHECK_EN
    dn_idx.delete(); dn_sc.delete();
    drv(1, 1, 16'd9, 0);
    drv(1, 1, 16'd8, 0);
    drv(1, 1, 16'd20, 0);
    drv(1, 1, 16'd1, 1);
    idle(4);
    chk("lenerr_flag", {31'b0, frame_error}, 32'd1);
    if (dn_idx.size() > 0) begin
      chk("lenerr_idx", {28'b0, dn_idx[0]}, 32'd2);
      chk("lenerr_score", {16'b0, dn_sc[0]}, 32'd20);
    end
    fr = '{16'd3, -16'sd1, 16'd7, 16'd2, 16'd0, 16'd5, 16'd7, 16'd1,
           -16'sd4, 16'd6};
    send_frame(-1);
    idle(4);
    chk("lenerr_sticky", {31'b0, frame_error}, 32'd1);
`else
    chk("no_err", {31'b0, frame_error}, 32'd0);
`endif

    // randomized frames with stalls, gaps and occasional resets
    for (int f = 0; f < 60; f++) begin
      for (int i = 0; i < NC; i++) begin
        logic [DW-1:0] d;
        bit en;
        bit l;
        drain();
        while ($urandom_range(0, 4) == 0)
          drv(($urandom_range(0, 1) != 0), 0, DW'($urandom), 0);
        if ($urandom_range(0, 60) == 0) begin
          @(negedge clock);
          reset = 1'b1;
          enable = 1'b1;
          result_valid = 1'b1;
          @(negedge clock);
          reset = 1'b0;
          result_valid = 1'b0;
        end
        if ($urandom_range(0, 1) != 0) d = DW'($urandom_range(0, 7) - 4);
        else d = DW'($urandom);
        l = (fq.size() == NC - 1);
`ifdef LENET_COLLECT_FRAME_CHECK_EN
        if ($urandom_range(0, 25) == 0) l = ~l;
`endif
        k = 0;
        do begin
          en = ($urandom_range(0, 5) != 0);
          drv(en, 1, d, l);
          k++;
        end while (!en && k < 50);
        drv(1, 0, '0, 0);
      end
    end
    drain();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected end");
    $fatal(1, "timeout");
  end

endmodule
